slicer_offset_cal: RTL

Clocked offset-calibration controller for the PWL slicer front end. During calibration, the slicer input is shorted, so its output reflects only the residual offset. The controller runs a successive-approximation (SAR) search on an offset DAC code, using windowed ones-counts of the slicer decision. The resulting code drives the DAC that produces the slicer's `offset` PWL input, so this block sits in the loop directly upstream of the slicer's offset port and downstream of its `out`.

---
 rtl/slicer_cal_pkg.sv | 19 +
 rtl/slicer_offset_cal_sync_2ff.sv | 21 ++
 rtl/slicer_offset_cal.sv | 137 +++++++++++++
 3 files changed

// File: rtl/slicer_cal_pkg.sv
// Shared types and helpers for the slicer offset calibration controller.
package slicer_cal_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    COUNT  = 3'd2,
    DECIDE = 3'd3,
    DONE   = 3'd4
  } cal_state_t;

  localparam int SYNC_DEPTH = 2;

  // Midpoint DAC code 2^(n-1), the first SAR trial.
  function automatic logic [31:0] mid_code(input int n);
    return 32'(1) << (n - 1);
  endfunction

endpackage

// File: rtl/slicer_offset_cal_sync_2ff.sv
// Two-flop synchronizer for the asynchronous slicer decision.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/slicer_offset_cal.sv
// SAR offset calibration for the slicer; SLICER_OFFSET_CAL_SYNC_EN adds a
// 2-flop synchronizer on slicer_out and stretches SETTLE to cover it.
module slicer_offset_cal
  import slicer_cal_pkg::*;
#(
  parameter int N_BITS     = 6,
  parameter int WIN_LOG2   = 5,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              slicer_out,
  output logic [N_BITS-1:0] code,
  output logic              busy,
  output logic              done,
  output logic              cal_fail,
  output cal_state_t        state
);

`ifdef SLICER_OFFSET_CAL_SYNC_EN
  localparam int SETTLE_LEN = SETTLE_CYC + SYNC_DEPTH;
`else
  localparam int SETTLE_LEN = SETTLE_CYC;
`endif
  localparam int SW    = $clog2(SETTLE_LEN + 1);
  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [N_BITS-1:0]   MID      = N_BITS'(mid_code(N_BITS));
  localparam logic [SW-1:0]       SET_LAST = SW'(SETTLE_LEN - 1);
  localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;
  localparam logic [WIN_LOG2:0]   HALF_WIN = (WIN_LOG2 + 1)'(1) << (WIN_LOG2 - 1);
  localparam logic [IDX_W-1:0]    TOP_IDX  = IDX_W'(N_BITS - 1);

  cal_state_t          state_n;
  logic [N_BITS-1:0]   code_n;
  logic                busy_n, done_n, fail_n;
  logic [SW-1:0]       settle_cnt, settle_n;
  logic [WIN_LOG2-1:0] win_cnt, win_n;
  logic [WIN_LOG2:0]   ones, ones_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic                sample;

`ifdef SLICER_OFFSET_CAL_SYNC_EN
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (slicer_out),
    .q   (sample)
  );
`else
  assign sample = slicer_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      code       <= MID;
      busy       <= 1'b0;
      done       <= 1'b0;
      cal_fail   <= 1'b0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      ones       <= '0;
      idx        <= '0;
    end else begin
      state      <= state_n;
      code       <= code_n;
      busy       <= busy_n;
      done       <= done_n;
      cal_fail   <= fail_n;
      settle_cnt <= settle_n;
      win_cnt    <= win_n;
      ones       <= ones_n;
      idx        <= idx_n;
    end
  end

  always_comb begin
    state_n  = state;
    code_n   = code;
    busy_n   = busy;
    done_n   = 1'b0;
    fail_n   = cal_fail;
    settle_n = settle_cnt;
    win_n    = win_cnt;
    ones_n   = ones;
    idx_n    = idx;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n  = SETTLE;
          idx_n    = TOP_IDX;
          code_n   = MID;
          fail_n   = 1'b0;
          busy_n   = 1'b1;
          settle_n = '0;
        end
      end
      SETTLE: begin
        ones_n = '0;
        win_n  = '0;
        if (settle_cnt == SET_LAST) begin
          settle_n = '0;
          state_n  = COUNT;
        end else begin
          settle_n = settle_cnt + SW'(1);
        end
      end
      COUNT: begin
        ones_n = ones + (WIN_LOG2 + 1)'(sample);
        win_n  = win_cnt + WIN_LOG2'(1);
        if (win_cnt == WIN_LAST) state_n = DECIDE;
      end
      DECIDE: begin
        // Ties keep the bit: at exactly half ones the offset is still too low.
        if (ones < HALF_WIN) code_n[idx] = 1'b0;
        if (idx == '0) begin
          state_n = DONE;
        end else begin
          idx_n             = idx - IDX_W'(1);
          code_n[idx_n]     = 1'b1;
          settle_n          = '0;
          state_n           = SETTLE;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        fail_n  = (code == '0) || (code == '1);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
